// File: rtl/dot_prod_mc.sv
// Multi-channel dot product: streams x against NCH coefficient tables and returns saturated sums.
// Latency L+5 cycles from start to strobe; no backpressure, and a new start aborts the run in flight.
module dot_prod_mc #(
    parameter int NCH = 2,
    parameter int PCW = 10,
    parameter int XW  = 18,
    parameter int KW  = 18,
    parameter int OW  = 18,
    parameter int PSH = 15,
    parameter int GW  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [PCW-1:0]        len,
    input  logic signed [XW-1:0]  x,
    input  logic [NCH*KW-1:0]     k_out,
    output logic [PCW-1:0]        k_out_addr,
    output logic [NCH*OW-1:0]     result,
    output logic [NCH-1:0]        sat_flag,
    output logic                  strobe,
    output logic                  busy
);
    localparam int TW = OW + 2;
    localparam int AW = TW + GW;
    localparam int PW = XW + KW;
    localparam logic signed [TW-1:0] T_MAX = {1'b0, {(TW-1){1'b1}}};
    localparam logic signed [TW-1:0] T_MIN = {1'b1, {(TW-1){1'b0}}};
    localparam logic signed [OW-1:0] O_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] O_MIN = {1'b1, {(OW-1){1'b0}}};

    logic [PCW-1:0]        r_pc;
    logic [PCW:0]          r_rem;
    logic                  r_busy;
    logic                  r_a_vld, r_a_fst, r_a_lst;
    // Tag stages: 0 = RAM data/x present, 1 = k/x registered, 2 = product, 3 = term
    logic [3:0]            r_vld, r_fst, r_lst;
    logic signed [KW-1:0]  r_k   [NCH];
    logic signed [XW-1:0]  r_x;
    logic signed [PW-1:0]  r_p   [NCH];
    logic signed [TW-1:0]  r_t   [NCH];
    logic signed [AW-1:0]  r_acc [NCH];
    logic [NCH-1:0]        r_sticky, r_sat_flag;
    logic [NCH*OW-1:0]     r_result;
    logic                  r_strobe;

    logic [PCW:0]          w_len_eff;
    logic signed [PW-1:0]  w_sh      [NCH];
    logic signed [TW-1:0]  w_t       [NCH];
    logic signed [AW-1:0]  w_acc_nxt [NCH];
    logic signed [OW-1:0]  w_res     [NCH];
    logic [NCH-1:0]        w_t_sat, w_fin_sat;
    logic                  w_final;

    assign w_len_eff = (len == '0) ? {1'b1, {PCW{1'b0}}} : {1'b0, len};
    assign w_final   = r_vld[3] && r_lst[3] && !start;

    always_comb begin
        w_t_sat   = '0;
        w_fin_sat = '0;
        for (int c = 0; c < NCH; c++) begin
            w_sh[c] = r_p[c] >>> PSH;
            w_t[c]  = w_sh[c][TW-1:0];
            if (!(&w_sh[c][PW-1:TW-1] || ~|w_sh[c][PW-1:TW-1])) begin
                w_t[c]     = w_sh[c][PW-1] ? T_MIN : T_MAX;
                w_t_sat[c] = 1'b1;
            end
            w_acc_nxt[c] = r_fst[3] ? {{GW{r_t[c][TW-1]}}, r_t[c]}
                                    : r_acc[c] + {{GW{r_t[c][TW-1]}}, r_t[c]};
            w_res[c] = w_acc_nxt[c][TW-1:2];
            if (!(&w_acc_nxt[c][AW-1:TW-1] || ~|w_acc_nxt[c][AW-1:TW-1])) begin
                w_res[c]     = w_acc_nxt[c][AW-1] ? O_MIN : O_MAX;
                w_fin_sat[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_a_vld    <= 1'b0;
            r_a_fst    <= 1'b0;
            r_a_lst    <= 1'b0;
            r_vld      <= '0;
            r_fst      <= '0;
            r_lst      <= '0;
            r_x        <= '0;
            r_sticky   <= '0;
            r_sat_flag <= '0;
            r_result   <= '0;
            r_strobe   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_k[c]   <= '0;
                r_p[c]   <= '0;
                r_t[c]   <= '0;
                r_acc[c] <= '0;
            end
        end else begin
            r_strobe <= 1'b0;
            if (start) begin
                r_pc    <= '0;
                r_rem   <= w_len_eff - (PCW+1)'(1);
                r_a_vld <= 1'b1;
                r_a_fst <= 1'b1;
                r_a_lst <= (w_len_eff == (PCW+1)'(1));
                r_busy  <= 1'b1;
            end else if (r_a_vld) begin
                if (r_rem != '0) begin
                    r_pc    <= r_pc + PCW'(1);
                    r_rem   <= r_rem - (PCW+1)'(1);
                    r_a_fst <= 1'b0;
                    r_a_lst <= (r_rem == (PCW+1)'(1));
                end else begin
                    r_a_vld <= 1'b0;
                end
            end
            // A restart flushes every tag so nothing of the aborted run reaches the accumulator
            r_vld <= start ? 4'b0000 : {r_vld[2:0], r_a_vld};
            r_fst <= {r_fst[2:0], r_a_fst};
            r_lst <= {r_lst[2:0], r_a_lst};
            r_x   <= x;
            for (int c = 0; c < NCH; c++) begin
                r_k[c] <= k_out[c*KW +: KW];
                r_p[c] <= PW'(r_k[c]) * PW'(r_x);
                r_t[c] <= w_t[c];
                if (r_vld[3]) r_acc[c] <= w_acc_nxt[c];
            end
            if (start || w_final) r_sticky <= '0;
            else if (r_vld[2])    r_sticky <= r_sticky | w_t_sat;
            if (w_final) begin
                for (int c = 0; c < NCH; c++) r_result[c*OW +: OW] <= w_res[c];
                r_sat_flag <= r_sticky | w_fin_sat;
                r_strobe   <= 1'b1;
                r_busy     <= 1'b0;
            end
        end
    end

    assign k_out_addr = r_pc;
    assign result     = r_result;
    assign sat_flag   = r_sat_flag;
    assign strobe     = r_strobe;
    assign busy       = r_busy | start;
endmodule

// File: tb/tb_dot_prod_mc.sv
// Directed bench for dot_prod_mc with PCW=4; a small synchronous RAM model supplies k and x.
module tb_dot_prod_mc;
    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic [3:0]         len;
    logic signed [17:0] x;
    logic [35:0]        k_out;
    logic [3:0]         k_out_addr;
    logic [35:0]        result;
    logic [1:0]         sat_flag;
    logic               strobe;
    logic               busy;

    logic signed [17:0] xm [16];
    logic signed [17:0] k0m[16];
    logic signed [17:0] k1m[16];
    logic signed [17:0] r0, r1;
    int n_chk = 0;
    int n_pass = 0;

    dot_prod_mc #(.NCH(2), .PCW(4), .XW(18), .KW(18), .OW(18), .PSH(15), .GW(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .x(x), .k_out(k_out),
        .k_out_addr(k_out_addr), .result(result), .sat_flag(sat_flag), .strobe(strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency coefficient RAM; x follows the same address so x[i] aligns with k[i]
    always @(posedge clk) begin
        x     <= xm[k_out_addr];
        k_out <= {k1m[k_out_addr], k0m[k_out_addr]};
    end

    assign r0 = result[17:0];
    assign r1 = result[35:18];

    task automatic fill(input int xv, input int k0v, input int k1v);
        for (int i = 0; i < 16; i++) begin
            xm[i] = 18'(xv); k0m[i] = 18'(k0v); k1m[i] = 18'(k1v);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; len = 4'd0;
        fill(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (strobe !== 1'b0) $display("FAIL reset_strobe: got %b expected 0", strobe); else n_pass++;
        n_chk++; if (result !== 36'd0) $display("FAIL reset_result: got %h expected 0", result); else n_pass++;
        n_chk++; if (sat_flag !== 2'b00) $display("FAIL reset_sat_flag: got %b expected 00", sat_flag); else n_pass++;
        n_chk++; if (k_out_addr !== 4'd0) $display("FAIL reset_addr: got %0d expected 0", k_out_addr); else n_pass++;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int sc = -1; int ns = 0; bit busy_ok = 1;
        logic signed [17:0] h0 = 0;
        fill(1000, 32768, -16384);
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1; start = (c == 0); len = 4'd4;
            @(negedge clk);
            if (strobe) begin ns++; if (sc < 0) sc = c; end
            if (c >= 1 && busy !== (c <= 8)) busy_ok = 0;
            if (c == 9) h0 = r0;
        end
        n_chk++; if (ns !== 1 || sc !== 9) $display("FAIL basic_strobe: got count %0d cycle %0d expected 1 at 9", ns, sc); else n_pass++;
        n_chk++; if (r0 !== 18'sd1000) $display("FAIL basic_result0: got %0d expected 1000", r0); else n_pass++;
        n_chk++; if (r1 !== -18'sd500) $display("FAIL basic_result1: got %0d expected -500", r1); else n_pass++;
        n_chk++; if (sat_flag !== 2'b00) $display("FAIL basic_sat_flag: got %b expected 00", sat_flag); else n_pass++;
        n_chk++; if (!busy_ok) $display("FAIL basic_busy: got wrong busy pattern expected high in cycles 1..8 only"); else n_pass++;
        n_chk++; if (h0 !== r0) $display("FAIL basic_hold: got %0d expected %0d", r0, h0); else n_pass++;
    endtask

    task automatic test_saturation();
        int sc = -1;
        fill(131071, 131071, -1);
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1; start = (c == 0); len = 4'd0;
            @(negedge clk);
            if (strobe && sc < 0) sc = c;
        end
        n_chk++; if (sc !== 21) $display("FAIL sat_strobe_cycle: got %0d expected 21", sc); else n_pass++;
        n_chk++; if (r0 !== 18'sd131071) $display("FAIL sat_result0: got %0d expected 131071", r0); else n_pass++;
        n_chk++; if (r1 !== -18'sd16) $display("FAIL sat_result1: got %0d expected -16", r1); else n_pass++;
        n_chk++; if (sat_flag !== 2'b01) $display("FAIL sat_flag: got %b expected 01", sat_flag); else n_pass++;
    endtask

    task automatic test_abort();
        int sc = -1; int ns = 0;
        for (int i = 0; i < 16; i++) begin
            xm[i] = 18'((i + 1) * 100); k0m[i] = 18'sd32768; k1m[i] = 18'sd65536;
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 3);
            len = (c == 3) ? 4'd2 : 4'd8;
            @(negedge clk);
            if (strobe) begin ns++; if (sc < 0) sc = c; end
        end
        n_chk++; if (ns !== 1 || sc !== 10) $display("FAIL abort_strobe: got count %0d cycle %0d expected 1 at 10", ns, sc); else n_pass++;
        n_chk++; if (r0 !== 18'sd75) $display("FAIL abort_result0: got %0d expected 75", r0); else n_pass++;
        n_chk++; if (r1 !== 18'sd150) $display("FAIL abort_result1: got %0d expected 150", r1); else n_pass++;
        n_chk++; if (sat_flag !== 2'b00) $display("FAIL abort_sat_flag: got %b expected 00", sat_flag); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int ns = 0; logic b8 = 1'b0;
        logic signed [17:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
        for (int i = 0; i < 16; i++) begin
            xm[i] = 18'((i + 1) * 100); k0m[i] = 18'sd32768; k1m[i] = 18'sd65536;
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 8); len = 4'd3;
            if (c == 8) for (int i = 0; i < 16; i++) xm[i] = -18'sd400;
            @(negedge clk);
            if (strobe) ns++;
            if (c == 8) begin b8 = busy; a0 = r0; a1 = r1; end
            if (c == 16) begin b0 = r0; b1 = r1; end
        end
        n_chk++; if (ns !== 2) $display("FAIL b2b_strobe_count: got %0d expected 2", ns); else n_pass++;
        n_chk++; if (b8 !== 1'b1) $display("FAIL b2b_busy_c8: got %b expected 1", b8); else n_pass++;
        n_chk++; if (a0 !== 18'sd150 || a1 !== 18'sd300) $display("FAIL b2b_run1: got %0d,%0d expected 150,300", a0, a1); else n_pass++;
        n_chk++; if (b0 !== -18'sd300 || b1 !== -18'sd600) $display("FAIL b2b_run2: got %0d,%0d expected -300,-600", b0, b1); else n_pass++;
    endtask

    task automatic test_len_zero();
        int sc = -1; bit addr_ok = 1;
        for (int i = 0; i < 16; i++) begin
            xm[i] = 18'((i + 1) * 100); k0m[i] = 18'sd32768; k1m[i] = -18'sd32768;
        end
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1; start = (c == 0); len = 4'd0;
            @(negedge clk);
            if (strobe && sc < 0) sc = c;
            if (c >= 1 && c <= 21 && k_out_addr !== ((c <= 16) ? 4'(c - 1) : 4'd15)) addr_ok = 0;
        end
        n_chk++; if (!addr_ok) $display("FAIL len0_addr: got wrong address sequence expected 0..15 then hold 15"); else n_pass++;
        n_chk++; if (sc !== 21) $display("FAIL len0_strobe_cycle: got %0d expected 21", sc); else n_pass++;
        n_chk++; if (r0 !== 18'sd3400 || r1 !== -18'sd3400) $display("FAIL len0_result: got %0d,%0d expected 3400,-3400", r0, r1); else n_pass++;
    endtask

    task automatic test_neg_fullscale();
        int sc = -1;
        fill(-131072, -131072, 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1; start = (c == 0); len = 4'd1;
            @(negedge clk);
            if (strobe && sc < 0) sc = c;
        end
        n_chk++; if (sc !== 6) $display("FAIL negfs_strobe_cycle: got %0d expected 6", sc); else n_pass++;
        n_chk++; if (r0 !== 18'sd131071 || r1 !== -18'sd1) $display("FAIL negfs_result: got %0d,%0d expected 131071,-1", r0, r1); else n_pass++;
        n_chk++; if (sat_flag !== 2'b01) $display("FAIL negfs_sat_flag: got %b expected 01", sat_flag); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int ns = 0; bit busy_ok = 1;
        fill(500, 32768, 32768);
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk); #1; start = (c == 0); len = 4'd8;
        end
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (result !== 36'd0) $display("FAIL rst_mid_result: got %h expected 0", result); else n_pass++;
        n_chk++; if (sat_flag !== 2'b00) $display("FAIL rst_mid_sat_flag: got %b expected 00", sat_flag); else n_pass++;
        n_chk++; if (strobe !== 1'b0 || k_out_addr !== 4'd0) $display("FAIL rst_mid_strobe_addr: got %b,%0d expected 0,0", strobe, k_out_addr); else n_pass++;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (strobe) ns++;
            if (busy !== 1'b0) busy_ok = 0;
        end
        n_chk++; if (ns !== 0) $display("FAIL rst_mid_no_strobe: got %0d strobes expected 0", ns); else n_pass++;
        n_chk++; if (!busy_ok || result !== 36'd0) $display("FAIL rst_mid_idle: got busy_ok %0d result %h expected 1 and 0", busy_ok, result); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_len_zero();
        test_neg_fullscale();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
